// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: shared FSM type, counter width and single-step Galois shift for the LFSR generators
package lfsr_rng_pkg;

    typedef enum logic {ST_WARMUP, ST_RUN} fsm_t;

    localparam int CNT_W = 8;
    localparam int LFSR_MAX_W = 64;

    // w selects the live state width; bits above w-1 come back cleared
    function automatic logic [LFSR_MAX_W-1:0] lfsr_rng_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    w
    );
        return ((state << 1) ^ (state[w-1] ? poly : '0)) & ({LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - w));
    endfunction

endpackage

// File: rtl/lfsr_rng_gen_if.sv
// lfsr_rng_gen_if: control, seed and valid/ready word port of the LFSR generator
interface lfsr_rng_gen_if #(
    parameter int WIDTH = 12,
    parameter int OUT_W = 12
);
    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             rand_ready;
    logic             rand_valid;
    logic [OUT_W-1:0] rand_num;
    logic             busy;
    logic             lockup_flag;

    modport master (
        input  enable, seed_load, seed_in, rand_ready,
        output rand_valid, rand_num, busy, lockup_flag
    );

    modport slave (
        output enable, seed_load, seed_in, rand_ready,
        input  rand_valid, rand_num, busy, lockup_flag
    );
endinterface

// File: rtl/lfsr_rng_unroll.sv
// lfsr_rng_unroll: STEPS chained Galois shifts, purely combinational
module lfsr_rng_unroll
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] POLY  = 12'hA97,
    parameter int               STEPS = 1
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);
    logic [WIDTH-1:0] chain [STEPS+1];

    assign chain[0] = state_in;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        assign chain[i+1] = WIDTH'(lfsr_rng_step(LFSR_MAX_W'(chain[i]), LFSR_MAX_W'(POLY), WIDTH));
    end

    assign state_out = chain[STEPS];
endmodule

// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen: parametrised Galois-LFSR word generator with seed load, warm-up and valid/ready output
// LFSR_RNG_LOCKUP_DET_EN: recover from a zero seed or zero state by reloading SEED and raising lockup_flag
module lfsr_rng_gen
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH  = 12,
    parameter logic [WIDTH-1:0] POLY   = 12'hA97,
    parameter logic [WIDTH-1:0] SEED   = 12'hAA7,
    parameter int               OUT_W  = 12,
    parameter int               STEPS  = 1,
    parameter int               WARMUP = 0
) (
    input logic            CLK,
    input logic            RST_N,
    lfsr_rng_gen_if.master bus
);
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_n;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] adv;
    logic [WIDTH-1:0] seed_val;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic             valid_q;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    fsm_t             fsm_q;
    fsm_t             fsm_d;

    lfsr_rng_unroll #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .STEPS (STEPS)
    ) u_unroll (
        .state_in  (state_q),
        .state_out (adv)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= SEED;
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= CNT_W'(WARMUP);
            fsm_q   <= ST_WARMUP;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            fsm_q   <= fsm_d;
        end
    end

    // seed_load wins over everything; a word offered in the same cycle is discarded
    always_comb begin
        state_n = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fsm_d   = fsm_q;
        if (bus.seed_load) begin
            state_n = seed_val;
            out_d   = '0;
            valid_d = 1'b0;
            cnt_d   = CNT_W'(WARMUP);
            fsm_d   = ST_WARMUP;
        end else if (fsm_q == ST_WARMUP) begin
            if (bus.enable) begin
                state_n = adv;
                cnt_d   = cnt_q - CNT_W'(cnt_q != '0);
                out_d   = (cnt_q == '0) ? adv[OUT_W-1:0] : out_q;
                valid_d = cnt_q == '0;
                fsm_d   = (cnt_q == '0) ? ST_RUN : ST_WARMUP;
            end
        end else if (bus.enable && (!valid_q || bus.rand_ready)) begin
            state_n = adv;
            out_d   = adv[OUT_W-1:0];
            valid_d = 1'b1;
        end else if (valid_q && bus.rand_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef LFSR_RNG_LOCKUP_DET_EN
    logic lock_q;
    logic lock_d;

    assign seed_val = (bus.seed_in == '0) ? SEED : bus.seed_in;
    assign state_d  = (!bus.seed_load && state_q == '0) ? SEED : state_n;
    assign lock_d   = bus.seed_load ? (bus.seed_in == '0) : (lock_q | (state_q == '0));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign bus.lockup_flag = lock_q;
`else
    assign seed_val        = bus.seed_in;
    assign state_d         = state_n;
    assign bus.lockup_flag = 1'b0;
`endif

    assign bus.rand_valid = valid_q;
    assign bus.rand_num   = out_q;
    assign bus.busy       = fsm_q == ST_WARMUP;
endmodule

// File: tb/tb_lfsr_rng_gen.sv
// tb_lfsr_rng_gen: scoreboard bench for two generator configurations against an arithmetic LFSR model
module tb_lfsr_rng_gen;
    logic CLK     = 1'b0;
    logic RST_N   = 1'b0;
    logic rst_b_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   a_acc   = 0;
    int   b_acc   = 0;

    logic [11:0] qa[$];
    logic [3:0]  qb[$];
    logic [11:0] ma;
    logic [3:0]  mb;
    logic        a_hold = 1'b0;
    logic [11:0] a_prev = '0;

    always #5 CLK = ~CLK;

    lfsr_rng_gen_if #(.WIDTH(12), .OUT_W(12)) a_if ();
    lfsr_rng_gen_if #(.WIDTH(4), .OUT_W(4)) b_if ();

    lfsr_rng_gen #(
        .WIDTH(12), .POLY(12'hA97), .SEED(12'hAA7), .OUT_W(12), .STEPS(1), .WARMUP(0)
    ) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (a_if)
    );

    lfsr_rng_gen #(
        .WIDTH(4), .POLY(4'h3), .SEED(4'h1), .OUT_W(4), .STEPS(1), .WARMUP(3)
    ) dut_b (
        .CLK   (CLK),
        .RST_N (rst_b_n),
        .bus   (b_if)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // doubling modulo 2^W, folding the carried-out bit back through the polynomial
    function automatic logic [11:0] ref_a(input logic [11:0] s);
        int v;
        v = int'(s) * 2;
        return (v >= 4096) ? (12'(v - 4096) ^ 12'hA97) : 12'(v);
    endfunction

    function automatic logic [3:0] ref_b(input logic [3:0] s);
        int v;
        v = int'(s) * 2;
        return (v >= 16) ? (4'(v - 16) ^ 4'h3) : 4'(v);
    endfunction

    task automatic a_fill();
        while (qa.size() < 16) begin
            ma = ref_a(ma);
            qa.push_back(ma);
        end
    endtask

    task automatic a_reseed(input logic [11:0] s);
        qa.delete();
        ma = s;
        a_fill();
    endtask

    task automatic b_fill();
        while (qb.size() < 16) begin
            mb = ref_b(mb);
            qb.push_back(mb);
        end
    endtask

    task automatic b_reseed(input logic [3:0] s);
        qb.delete();
        mb = s;
        repeat (3) mb = ref_b(mb);
        b_fill();
    endtask

    always @(negedge CLK) begin
        if (RST_N && a_hold) begin
            check("a_stall_valid", a_if.rand_valid, 1);
            check("a_stall_num", a_if.rand_num, a_prev);
        end
        if (RST_N && a_if.rand_valid && a_if.rand_ready && !a_if.seed_load) begin
            a_acc++;
            check("a_sb_nonempty", qa.size() > 0, 1);
            if (qa.size() > 0) check("a_word", a_if.rand_num, qa.pop_front());
        end
        a_hold <= RST_N && a_if.rand_valid && !a_if.rand_ready && !a_if.seed_load;
        a_prev <= a_if.rand_num;
    end

    always @(negedge CLK) begin
        if (rst_b_n && b_if.rand_valid && b_if.rand_ready && !b_if.seed_load) begin
            b_acc++;
            check("b_sb_nonempty", qb.size() > 0, 1);
            if (qb.size() > 0) check("b_word", b_if.rand_num, qb.pop_front());
        end
    end

    task automatic run_a();
        logic [11:0] seq [3];
        seq = '{12'hFD9, 12'h525, 12'hA4A};
        a_if.enable = 1'b0;
        a_if.seed_load = 1'b0;
        a_if.seed_in = '0;
        a_if.rand_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("a_rst_valid", a_if.rand_valid, 0);
        check("a_rst_num", a_if.rand_num, 0);
        check("a_rst_busy", a_if.busy, 1);
        check("a_rst_lockup", a_if.lockup_flag, 0);
        RST_N = 1'b1;
        a_reseed(12'hAA7);
        a_if.enable = 1'b1;
        a_if.rand_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check("a_seq_valid", a_if.rand_valid, 1);
            check("a_seq_busy", a_if.busy, 0);
            check("a_seq_num", a_if.rand_num, seq[k]);
            a_fill();
        end
        a_if.seed_load = 1'b1;
        a_if.seed_in = 12'hAA7;
        a_if.rand_ready = 1'b0;
        a_reseed(12'hAA7);
        @(posedge CLK); #1;
        check("a_reload_valid", a_if.rand_valid, 0);
        check("a_reload_busy", a_if.busy, 1);
        a_if.seed_load = 1'b0;
        @(posedge CLK); #1;
        check("a_pend_num", a_if.rand_num, 12'hFD9);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            check("a_hold_num", a_if.rand_num, 12'hFD9);
            check("a_hold_valid", a_if.rand_valid, 1);
        end
        a_if.rand_ready = 1'b1;
        @(posedge CLK); #1;
        check("a_release_num", a_if.rand_num, 12'h525);
        a_if.seed_load = 1'b1;
        a_if.seed_in = 12'h001;
        a_reseed(12'h001);
        @(posedge CLK); #1;
        check("a_drop_valid", a_if.rand_valid, 0);
        a_if.seed_load = 1'b0;
        @(posedge CLK); #1;
        check("a_seed1_num", a_if.rand_num, 12'h002);
        check("a_seed1_valid", a_if.rand_valid, 1);
        for (int n = 0; n < 400; n++) begin
            @(posedge CLK); #1;
            a_if.enable = $urandom_range(0, 3) != 0;
            a_if.rand_ready = $urandom_range(0, 2) != 0;
            a_if.seed_load = $urandom_range(0, 49) == 0;
            if (a_if.seed_load) begin
                a_if.seed_in = 12'($urandom_range(1, 4095));
                a_reseed(a_if.seed_in);
            end
            a_fill();
        end
        @(posedge CLK); #1;
        a_if.enable = 1'b1;
        a_if.rand_ready = 1'b1;
        a_if.seed_load = 1'b1;
        a_if.seed_in = '0;
`ifdef LFSR_RNG_LOCKUP_DET_EN
        a_reseed(12'hAA7);
`else
        a_reseed(12'h000);
`endif
        @(posedge CLK); #1;
        a_if.seed_load = 1'b0;
        check("a_zero_valid", a_if.rand_valid, 0);
`ifdef LFSR_RNG_LOCKUP_DET_EN
        check("a_zero_lockup", a_if.lockup_flag, 1);
        @(posedge CLK); #1;
        check("a_zero_restart", a_if.rand_num, 12'hFD9);
`else
        check("a_zero_lockup", a_if.lockup_flag, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            check("a_zero_stuck", a_if.rand_num, 0);
            check("a_zero_lockoff", a_if.lockup_flag, 0);
        end
`endif
        a_if.seed_load = 1'b1;
        a_if.seed_in = 12'h123;
        a_reseed(12'h123);
        @(posedge CLK); #1;
        a_if.seed_load = 1'b0;
        check("a_lock_clear", a_if.lockup_flag, 0);
        for (int n = 0; n < 20; n++) begin
            @(posedge CLK); #1;
            a_fill();
        end
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        check("a_async_valid", a_if.rand_valid, 0);
        check("a_async_num", a_if.rand_num, 0);
        check("a_async_busy", a_if.busy, 1);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        a_reseed(12'hAA7);
        @(posedge CLK); #1;
        check("a_after_rst", a_if.rand_num, 12'hFD9);
        a_if.enable = 1'b0;
        a_if.rand_ready = 1'b0;
        repeat (2) @(posedge CLK);
        check("a_accepted", a_acc >= 100, 1);
    endtask

    task automatic run_b();
        b_if.enable = 1'b0;
        b_if.seed_load = 1'b0;
        b_if.seed_in = '0;
        b_if.rand_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("b_rst_busy", b_if.busy, 1);
        check("b_rst_valid", b_if.rand_valid, 0);
        rst_b_n = 1'b1;
        b_reseed(4'h1);
        b_if.rand_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            b_if.enable = n != 2 && n != 3;
            @(posedge CLK); #1;
            check("b_warm_busy", b_if.busy, 1);
            check("b_warm_valid", b_if.rand_valid, 0);
        end
        b_if.enable = 1'b1;
        @(posedge CLK); #1;
        check("b_first_num", b_if.rand_num, 4'h3);
        check("b_first_busy", b_if.busy, 0);
        for (int n = 0; n < 15; n++) begin
            @(posedge CLK); #1;
            b_fill();
        end
        check("b_period", b_if.rand_num, 4'h3);
        for (int n = 0; n < 300; n++) begin
            @(posedge CLK); #1;
            b_if.enable = $urandom_range(0, 2) != 0;
            b_if.rand_ready = $urandom_range(0, 1) != 0;
            b_fill();
        end
        b_if.enable = 1'b0;
        b_if.rand_ready = 1'b0;
        repeat (2) @(posedge CLK);
        check("b_accepted", b_acc >= 60, 1);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
